alu_exec_stage: RTL and testbench

ALU_EXEC_STAGE -- requirements
Module: alu_exec_stage

---
 rtl/alu_exec_stage.sv | 132 +++++++++++++
 tb/tb_alu_exec_stage.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/alu_exec_stage.sv
// Execute stage that registers ALU operands and waits an opcode-dependent latency
// before capturing the downstream ALU result. DIV by zero completes immediately.
module alu_exec_stage #(
    parameter int MULT_CYCLES = 4,
    parameter int DIV_CYCLES  = 8
) (
    input  logic        iClk,
    input  logic        iReset,
    input  logic        iStart,
    input  logic [31:0] iA,
    input  logic [31:0] iB,
    input  logic [3:0]  iControlSignal,
    input  logic [31:0] iALUresult,
    output logic [31:0] oOperandA,
    output logic [31:0] oOperandB,
    output logic [3:0]  oALUControl,
    output logic [31:0] oALUOut,
    output logic        oZero,
    output logic        oDivByZero,
    output logic        oBusy,
    output logic        oDone
);

    typedef enum logic [1:0] {
        IDLE,
        EXEC,
        DONE
    } state_t;

    localparam logic [3:0] OP_MULT  = 4'b0111;
    localparam logic [3:0] OP_DIV   = 4'b1000;
    localparam logic [3:0] MULT_LAT = 4'(MULT_CYCLES);
    localparam logic [3:0] DIV_LAT  = 4'(DIV_CYCLES);

    state_t      state_q, state_d;
    logic [3:0]  count_q, count_d;
    logic [31:0] operand_a_q, operand_a_d;
    logic [31:0] operand_b_q, operand_b_d;
    logic [3:0]  alu_ctrl_q, alu_ctrl_d;
    logic [31:0] alu_out_q, alu_out_d;
    logic        zero_q, zero_d;
    logic        div_zero_q, div_zero_d;

    function automatic logic [3:0] op_latency(input logic [3:0] op);
        case (op)
            OP_MULT: op_latency = MULT_LAT;
            OP_DIV:  op_latency = DIV_LAT;
            default: op_latency = 4'd1;
        endcase
    endfunction

    always_comb begin
        state_d     = state_q;
        count_d     = count_q;
        operand_a_d = operand_a_q;
        operand_b_d = operand_b_q;
        alu_ctrl_d  = alu_ctrl_q;
        alu_out_d   = alu_out_q;
        zero_d      = zero_q;
        div_zero_d  = div_zero_q;

        case (state_q)
            IDLE: begin
                if (iStart) begin
                    operand_a_d = iA;
                    operand_b_d = iB;
                    alu_ctrl_d  = iControlSignal;
                    count_d     = op_latency(iControlSignal);
                    // Divide by zero never reaches the ALU; the result is forced here.
                    if (iControlSignal == OP_DIV && iB == 32'd0) begin
                        alu_out_d  = 32'd0;
                        zero_d     = 1'b1;
                        div_zero_d = 1'b1;
                        count_d    = 4'd0;
                        state_d    = DONE;
                    end else begin
                        state_d = EXEC;
                    end
                end
            end
            EXEC: begin
                if (count_q != 4'd1) begin
                    count_d = count_q - 4'd1;
                end else begin
                    alu_out_d  = iALUresult;
                    zero_d     = (iALUresult == 32'd0);
                    div_zero_d = 1'b0;
                    count_d    = 4'd0;
                    state_d    = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge iClk or posedge iReset) begin
        if (iReset) begin
            state_q     <= IDLE;
            count_q     <= 4'd0;
            operand_a_q <= 32'd0;
            operand_b_q <= 32'd0;
            alu_ctrl_q  <= 4'd0;
            alu_out_q   <= 32'd0;
            zero_q      <= 1'b0;
            div_zero_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            count_q     <= count_d;
            operand_a_q <= operand_a_d;
            operand_b_q <= operand_b_d;
            alu_ctrl_q  <= alu_ctrl_d;
            alu_out_q   <= alu_out_d;
            zero_q      <= zero_d;
            div_zero_q  <= div_zero_d;
        end
    end

    assign oOperandA   = operand_a_q;
    assign oOperandB   = operand_b_q;
    assign oALUControl = alu_ctrl_q;
    assign oALUOut     = alu_out_q;
    assign oZero       = zero_q;
    assign oDivByZero  = div_zero_q;
    assign oBusy       = (state_q == EXEC);
    assign oDone       = (state_q == DONE);

endmodule

// File: tb/tb_alu_exec_stage.sv
// Directed bench for alu_exec_stage with a behavioural downstream ALU and
// hand-computed expected results, latencies and flag values.
module tb_alu_exec_stage;

    logic        iClk = 1'b0;
    logic        iReset;
    logic        iStart;
    logic [31:0] iA;
    logic [31:0] iB;
    logic [3:0]  iControlSignal;
    logic [31:0] iALUresult;
    logic [31:0] oOperandA;
    logic [31:0] oOperandB;
    logic [3:0]  oALUControl;
    logic [31:0] oALUOut;
    logic        oZero;
    logic        oDivByZero;
    logic        oBusy;
    logic        oDone;

    int checks = 0;
    int errors = 0;
    int cycles;
    int busyCycles;

    always #5 iClk = ~iClk;

    alu_exec_stage #(
        .MULT_CYCLES(4),
        .DIV_CYCLES (8)
    ) dut (
        .iClk          (iClk),
        .iReset        (iReset),
        .iStart        (iStart),
        .iA            (iA),
        .iB            (iB),
        .iControlSignal(iControlSignal),
        .iALUresult    (iALUresult),
        .oOperandA     (oOperandA),
        .oOperandB     (oOperandB),
        .oALUControl   (oALUControl),
        .oALUOut       (oALUOut),
        .oZero         (oZero),
        .oDivByZero    (oDivByZero),
        .oBusy         (oBusy),
        .oDone         (oDone)
    );

    // Downstream ALU; a DIV by zero yields a marker so an illegal sample is visible.
    always_comb begin
        iALUresult = 32'h0;
        case (oALUControl)
            4'b0000: iALUresult = oOperandA & oOperandB;
            4'b0001: iALUresult = oOperandA | oOperandB;
            4'b0010: iALUresult = oOperandA + oOperandB;
            4'b0011: iALUresult = oOperandA - oOperandB;
            4'b0100: iALUresult = oOperandA ^ oOperandB;
            4'b0101: iALUresult = ~(oOperandA | oOperandB);
            4'b0111: iALUresult = oOperandA * oOperandB;
            4'b1000: iALUresult = (oOperandB == 0) ? 32'hDEAD_BEEF : oOperandA / oOperandB;
            default: iALUresult = 32'h0;
        endcase
    end

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Presents one request for a single edge; returns #1 after the accepting edge.
    task automatic applyStimulus(input logic [31:0] a, input logic [31:0] b, input logic [3:0] op);
        @(negedge iClk);
        iA = a;
        iB = b;
        iControlSignal = op;
        iStart = 1'b1;
        @(posedge iClk);
        #1;
        iStart = 1'b0;
    endtask

    task automatic waitDone(input int budget, output int nCycles, output int nBusy);
        nCycles = 0;
        nBusy = 0;
        while (!oDone && nCycles < budget) begin
            if (oBusy) nBusy++;
            @(posedge iClk);
            #1;
            nCycles++;
        end
        checkOutput("doneReached", {31'b0, oDone}, 32'd1);
    endtask

    task automatic checkDonePulseEnds();
        @(posedge iClk);
        #1;
        checkOutput("donePulseOneCycle", {31'b0, oDone}, 32'd0);
        checkOutput("idleAfterDone", {31'b0, oBusy}, 32'd0);
    endtask

    task automatic runOp(input string tag, input logic [31:0] a, input logic [31:0] b,
                         input logic [3:0] op, input int lat, input logic [31:0] expOut,
                         input logic expZero);
        applyStimulus(a, b, op);
        waitDone(40, cycles, busyCycles);
        checkOutput({tag, "_latency"}, 32'(cycles), 32'(lat));
        checkOutput({tag, "_busyCycles"}, 32'(busyCycles), 32'(lat));
        checkOutput({tag, "_out"}, oALUOut, expOut);
        checkOutput({tag, "_zero"}, {31'b0, oZero}, {31'b0, expZero});
        checkOutput({tag, "_div0"}, {31'b0, oDivByZero}, 32'd0);
        checkDonePulseEnds();
    endtask

    initial begin
        iReset = 1'b1;
        iStart = 1'b0;
        iA = 32'd0;
        iB = 32'd0;
        iControlSignal = 4'd0;
        #3;
        checkOutput("rst_out", oALUOut, 32'd0);
        checkOutput("rst_zero", {31'b0, oZero}, 32'd0);
        checkOutput("rst_div0", {31'b0, oDivByZero}, 32'd0);
        checkOutput("rst_busy", {31'b0, oBusy}, 32'd0);
        checkOutput("rst_done", {31'b0, oDone}, 32'd0);
        checkOutput("rst_opA", oOperandA, 32'd0);
        checkOutput("rst_ctrl", {28'b0, oALUControl}, 32'd0);
        repeat (2) @(negedge iClk);
        iReset = 1'b0;

        // Single-cycle ops
        runOp("add", 32'd5, 32'd7, 4'b0010, 1, 32'd12, 1'b0);
        runOp("subZero", 32'h1234, 32'h1234, 4'b0011, 1, 32'd0, 1'b1);
        runOp("and", 32'hF0F0_FF00, 32'h0FF0_F0F0, 4'b0000, 1, 32'h00F0_F000, 1'b0);
        runOp("or", 32'hF000_0001, 32'h0000_0F00, 4'b0001, 1, 32'hF000_0F01, 1'b0);
        runOp("xor", 32'hAAAA_5555, 32'hFFFF_0000, 4'b0100, 1, 32'h5555_5555, 1'b0);
        runOp("nor", 32'hFFFF_0000, 32'h0000_FF00, 4'b0101, 1, 32'h0000_00FF, 1'b0);
        runOp("undefOp", 32'd3, 32'd4, 4'b1111, 1, 32'd0, 1'b1);

        // MULT with operand changes during EXEC that must be ignored
        applyStimulus(32'd6, 32'd7, 4'b0111);
        iA = 32'd99;
        iB = 32'd99;
        iControlSignal = 4'b0000;
        @(posedge iClk);
        #1;
        checkOutput("mult_opAStable", oOperandA, 32'd6);
        checkOutput("mult_opBStable", oOperandB, 32'd7);
        waitDone(40, cycles, busyCycles);
        checkOutput("mult_latency", 32'(cycles + 1), 32'd4);
        checkOutput("mult_busyCycles", 32'(busyCycles + 1), 32'd4);
        checkOutput("mult_out", oALUOut, 32'd42);
        checkDonePulseEnds();
        checkOutput("mult_outHeld", oALUOut, 32'd42);

        // DIV by zero bypasses EXEC, then an add clears the flag
        applyStimulus(32'd9, 32'd0, 4'b1000);
        checkOutput("div0_doneImmediate", {31'b0, oDone}, 32'd1);
        checkOutput("div0_busy", {31'b0, oBusy}, 32'd0);
        checkOutput("div0_out", oALUOut, 32'd0);
        checkOutput("div0_zero", {31'b0, oZero}, 32'd1);
        checkOutput("div0_flag", {31'b0, oDivByZero}, 32'd1);
        checkDonePulseEnds();
        checkOutput("div0_flagHeld", {31'b0, oDivByZero}, 32'd1);
        runOp("addAfterDiv0", 32'd1, 32'd2, 4'b0010, 1, 32'd3, 1'b0);

        // DIV 100/5 with iStart held through EXEC and DONE
        applyStimulus(32'd100, 32'd5, 4'b1000);
        iStart = 1'b1;
        iControlSignal = 4'b0000;
        iA = 32'hFFFF_FFFF;
        iB = 32'hFFFF_FFFF;
        waitDone(40, cycles, busyCycles);
        checkOutput("div_latency", 32'(cycles), 32'd8);
        checkOutput("div_busyCycles", 32'(busyCycles), 32'd8);
        checkOutput("div_out", oALUOut, 32'd20);
        checkOutput("div_ctrlStable", {28'b0, oALUControl}, 32'h8);
        @(posedge iClk);
        #1;
        iStart = 1'b0;
        checkOutput("div_startIgnoredInDone", {31'b0, oBusy}, 32'd0);
        checkOutput("div_doneEnds", {31'b0, oDone}, 32'd0);
        checkOutput("div_ctrlNotReloaded", {28'b0, oALUControl}, 32'h8);

        // Reset during MULT EXEC cycle 2
        applyStimulus(32'd6, 32'd7, 4'b0111);
        @(posedge iClk);
        #2;
        iReset = 1'b1;
        #1;
        checkOutput("rstMid_busy", {31'b0, oBusy}, 32'd0);
        checkOutput("rstMid_done", {31'b0, oDone}, 32'd0);
        checkOutput("rstMid_out", oALUOut, 32'd0);
        checkOutput("rstMid_opA", oOperandA, 32'd0);
        checkOutput("rstMid_opB", oOperandB, 32'd0);
        checkOutput("rstMid_ctrl", {28'b0, oALUControl}, 32'd0);
        checkOutput("rstMid_zero", {31'b0, oZero}, 32'd0);
        repeat (3) begin
            @(posedge iClk);
            #1;
            checkOutput("rstHeld_done", {31'b0, oDone}, 32'd0);
        end
        @(negedge iClk);
        iReset = 1'b0;
        iA = 32'd1;
        iB = 32'd1;
        iControlSignal = 4'b0010;
        iStart = 1'b1;
        @(posedge iClk);
        #1;
        iStart = 1'b0;
        checkOutput("postRst_accepted", {31'b0, oBusy}, 32'd1);
        waitDone(40, cycles, busyCycles);
        checkOutput("postRst_out", oALUOut, 32'd2);
        checkDonePulseEnds();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("[TB] FAIL globalTimeout: simulation did not finish");
        $fatal(1, "[TB] timeout");
    end

endmodule
